pix_row_packer: RTL and testbench
=================================

PIX_ROW_PACKER -- requirements
Module: pix_row_packer

Interface
REQ-001 Parameter COL, default 256, pixels per row and rows per frame.
REQ-002 Parameter WIDTH, default 8, bits per colour channel; a pixel is 3*WIDTH bits.
REQ-003 CLK  input  1  clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-low.
REQ-005 pix_in  input  3*WIDTH  pixel; R in bits [23:16], G in [15:8], B in [7:0].
REQ-006 pix_valid  input  1  pix_in is valid this cycle.
REQ-007 pix_sof  input  1  start of frame; qualified by pix_valid, marks column 0 of row 0.
REQ-008 pix_ready  output  1  block accepts pix_in this cycle.
REQ-009 row_out  output  COL*3*WIDTH  assembled row; pixel k in row_out[COL*24-1-24k -: 24], so pixel 0 is in the MSBs.
REQ-010 row_valid  output  1  row_out holds an unconsumed row.
REQ-011 row_ready  input  1  downstream filter consumes row_out this cycle.
REQ-012 row_idx  output  8  row number of the row currently in row_out, 0..COL-1.
REQ-013 frame_done  output  1  one-cycle pulse when row COL-1 is consumed.
REQ-014 sof_err  output  1  sticky flag; set by a mid-frame pix_sof, cleared only by RST.

Function
REQ-015 Accept rule: a pixel is accepted on a cycle where pix_valid=1 and pix_ready=1.
REQ-016 The block SHALL contain a fill buffer of COL pixels, a column counter col_cnt (0..COL-1) and a row counter row_cnt (0..COL-1), plus the row_out output register; this gives two row stages (double buffering).
REQ-017 States: IDLE, FILL, FULL, DRAIN.
REQ-018 IDLE: pix_ready=1; an accepted pixel with pix_sof=0 is discarded; an accepted pixel with pix_sof=1 is written to column 0, col_cnt becomes 1, row_cnt becomes 0, next state FILL.
REQ-019 FILL: pix_ready=1; each accepted pixel is written to column col_cnt and col_cnt increments; the pixel accepted at col_cnt=COL-1 completes the row, wraps col_cnt to 0 and moves to FULL.
REQ-020 FULL: pix_ready=0; the fill buffer is copied to row_out, with row_idx<=row_cnt and row_valid<=1, on the first cycle where row_valid=0 or row_ready=1.
REQ-021 On that transfer, row_cnt increments; if the transferred row was COL-1, go to DRAIN, otherwise go to FILL.
REQ-022 Latency: when row_out is free, row_valid SHALL rise on the first edge after the completing pixel's acceptance edge plus one FULL cycle (2 edges); no completed row is ever dropped or overwritten.
REQ-023 Consume rule: row_valid=1 and row_ready=1 with no transfer on the same edge clears row_valid; a transfer on the same edge keeps row_valid=1 with new contents (back-to-back rows).
REQ-024 DRAIN: pix_ready=0; when the last row (row_idx=COL-1) is consumed, frame_done pulses for 1 cycle, row_valid clears and the state returns to IDLE.
REQ-025 Mid-frame sof: an accepted pix_sof=1 in FILL with col_cnt!=0 or row_cnt!=0 SHALL set sof_err, discard the partial row, and restart with that pixel at column 0 of row 0; a row already in row_out is unaffected.
REQ-026 pix_sof=1 at col_cnt=0, row_cnt=0 in FILL is legal and does not set sof_err.
REQ-027 row_out, row_idx and row_valid SHALL be stable while row_valid=1 and row_ready=0.
REQ-028 Widths: col_cnt and row_cnt are clog2(COL) bits and wrap only via the rules above; row_idx is zero-extended to 8 bits.

Reset
REQ-029 RST=0 SHALL immediately force state=IDLE, col_cnt=0, row_cnt=0, row_valid=0, row_idx=0, frame_done=0, sof_err=0, row_out=0; pix_ready=1 while in IDLE after release.
REQ-030 Reset mid-frame discards all buffered data; after RST returns to 1, the block waits for a new pix_sof.

Verification
REQ-031 Single row: after RST, stream pixels 0..255 with pix_sof on pixel 0 and pixel k = {k,k,~k}, row_ready=1 -> row_valid for 1 cycle, row_idx=0, row_out[6143:6120]=24'h0000FF, row_out[23:0]=24'hFFFF00.
REQ-032 Backpressure: hold row_ready=0 and stream 2 full rows -> pix_ready=0 after pixel 511 is accepted, row 0 stays stable; raise row_ready -> row 1 appears on the next edge with row_idx=1.
REQ-033 Full frame: stream 65536 continuous pixels, row_ready=1 -> 256 row_valid pulses with row_idx 0..255 in order, one frame_done on consumption of row 255, then state IDLE.
REQ-034 Pre-sof garbage: 10 pixels with pix_sof=0 in IDLE, then a frame -> first row column 0 equals the pix_sof pixel; sof_err=0.
REQ-035 Mid-frame sof: pix_sof asserted at col_cnt=100 of row 3 -> sof_err=1 and stays 1; the next emitted row has row_idx=0 and column 0 equal to the sof pixel.
REQ-036 Async reset: RST=0 pulsed for half a cycle mid-row while row_valid=1 -> row_valid=0 immediately, no frame_done, and pixels without pix_sof are ignored afterwards.

Source files
------------

// File: rtl/pix_row_packer_if.sv
// Pixel-stream and row-output bundle for pix_row_packer.
// The slave modport is the packer's view; the master modport is the
// view of whatever feeds pixels and consumes rows.
interface pix_row_packer_if #(
    parameter int COL   = 256,
    parameter int WIDTH = 8
);
    logic [3*WIDTH-1:0]     pix_in;
    logic                   pix_valid;
    logic                   pix_sof;
    logic                   pix_ready;
    logic [COL*3*WIDTH-1:0] row_out;
    logic                   row_valid;
    logic                   row_ready;
    logic [7:0]             row_idx;
    logic                   frame_done;
    logic                   sof_err;

    modport slave (
        input  pix_in, pix_valid, pix_sof, row_ready,
        output pix_ready, row_out, row_valid, row_idx, frame_done, sof_err
    );

    modport master (
        output pix_in, pix_valid, pix_sof, row_ready,
        input  pix_ready, row_out, row_valid, row_idx, frame_done, sof_err
    );
endinterface

// File: rtl/pix_row_packer.sv
// Packs a pixel stream into full rows of COL pixels, one row per transfer.
// A fill buffer collects the current row while the previously completed
// row sits in row_out, so a downstream consumer can hold off for up to a
// full row time without stalling the pixel stream.
module pix_row_packer #(
    parameter int COL   = 256,
    parameter int WIDTH = 8
) (
    input logic CLK,
    input logic RST,
    pix_row_packer_if.slave bus
);
    localparam int PW = 3 * WIDTH;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam logic [CW-1:0] LAST = CW'(COL - 1);

    typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_t;

    state_t             state_reg;
    logic [CW-1:0]      col_cnt_reg;
    logic [CW-1:0]      row_cnt_reg;
    logic               pix_ready_reg;
    logic               row_valid_reg;
    logic               frame_done_reg;
    logic               sof_err_reg;
    logic [7:0]         row_idx_reg;
    logic [COL*PW-1:0]  row_out_reg;

    logic [PW-1:0]      fill_buf [COL];
    logic [COL*PW-1:0]  fill_flat;

    logic               accept;
    logic               wr_en;
    logic [CW-1:0]      wr_col;
    logic               row_done;
    logic               transfer;
    logic               consume;

    // Decode the handshakes: which column (if any) is written, whether that
    // write completes the row, and whether row_out is loaded or consumed.
    always_comb begin
        accept   = bus.pix_valid && pix_ready_reg;
        // In IDLE only a start-of-frame pixel is kept; FILL keeps everything.
        wr_en    = accept && (bus.pix_sof || (state_reg == FILL));
        // A start-of-frame pixel always restarts at column 0.
        wr_col   = bus.pix_sof ? '0 : col_cnt_reg;
        row_done = (wr_col == LAST);
        transfer = (state_reg == FULL) && (!row_valid_reg || bus.row_ready);
        consume  = row_valid_reg && bus.row_ready;
    end

    // Fill buffer write port; contents need no reset since every row is
    // fully rewritten before it is ever copied out.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            fill_buf[wr_col] <= bus.pix_in;
        end
    end

    // Flatten the fill buffer with column 0 in the most significant slot.
    generate
        for (genvar gi = 0; gi < COL; gi++) begin : g_flat
            assign fill_flat[COL*PW-1-PW*gi -: PW] = fill_buf[gi];
        end
    endgenerate

    // Control FSM with registered outputs; row_out is loaded from the fill
    // buffer in FULL as soon as the output stage is empty or being drained.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg      <= IDLE;
            col_cnt_reg    <= '0;
            row_cnt_reg    <= '0;
            pix_ready_reg  <= 1'b1;
            row_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            sof_err_reg    <= 1'b0;
            row_idx_reg    <= '0;
            row_out_reg    <= '0;
        end else begin
            frame_done_reg <= 1'b0;

            // A plain consume empties row_out; a same-edge transfer below
            // overrides this and keeps row_valid high with the new row.
            if (consume && !transfer) begin
                row_valid_reg <= 1'b0;
            end

            if (wr_en) begin
                col_cnt_reg <= row_done ? '0 : wr_col + CW'(1);
                if (bus.pix_sof) begin
                    row_cnt_reg <= '0;
                    if ((state_reg == FILL) &&
                        ((col_cnt_reg != '0) || (row_cnt_reg != '0))) begin
                        sof_err_reg <= 1'b1;
                    end
                end
                if (row_done) begin
                    state_reg     <= FULL;
                    pix_ready_reg <= 1'b0;
                end else begin
                    state_reg     <= FILL;
                end
            end

            if (transfer) begin
                row_out_reg   <= fill_flat;
                row_idx_reg   <= 8'(row_cnt_reg);
                row_valid_reg <= 1'b1;
                if (row_cnt_reg == LAST) begin
                    row_cnt_reg <= '0;
                    state_reg   <= DRAIN;
                end else begin
                    row_cnt_reg   <= row_cnt_reg + CW'(1);
                    state_reg     <= FILL;
                    pix_ready_reg <= 1'b1;
                end
            end

            // The last row of the frame leaving row_out ends the frame.
            if ((state_reg == DRAIN) && consume) begin
                frame_done_reg <= 1'b1;
                state_reg      <= IDLE;
                pix_ready_reg  <= 1'b1;
            end
        end
    end

    assign bus.pix_ready  = pix_ready_reg;
    assign bus.row_out    = row_out_reg;
    assign bus.row_valid  = row_valid_reg;
    assign bus.row_idx    = row_idx_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.sof_err    = sof_err_reg;
endmodule

// File: tb/tb_pix_row_packer.sv
// Directed bench for pix_row_packer: single row, backpressure, mid-frame
// start-of-frame, pre-frame garbage plus a full frame, and async reset.
module tb_pix_row_packer;
    localparam int COL   = 256;
    localparam int WIDTH = 8;
    localparam int PW    = 3 * WIDTH;
    localparam int RW    = COL * PW;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    int cons_n = 0;
    int fd_n   = 0;
    logic [7:0]    cons_idx  [1024];
    logic [PW-1:0] cons_col0 [1024];

    // Free-running clock.
    always #5 CLK = ~CLK;

    pix_row_packer_if #(.COL(COL), .WIDTH(WIDTH)) bus ();

    pix_row_packer #(.COL(COL), .WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Record every row consumption and frame_done pulse, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RST && bus.row_valid && bus.row_ready) begin
            if (cons_n < 1024) begin
                cons_idx[cons_n]  = bus.row_idx;
                cons_col0[cons_n] = bus.row_out[RW-1 -: PW];
            end
            cons_n++;
        end
        if (bus.frame_done) begin
            fd_n++;
        end
    end

    // Global time bound.
    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one pixel and hold it until accepted.
    task automatic send(input logic [PW-1:0] p, input logic s);
        int w;
        w = 0;
        bus.pix_in    = p;
        bus.pix_sof   = s;
        bus.pix_valid = 1'b1;
        while (!bus.pix_ready && w < 2000) begin
            tick();
            w++;
        end
        if (w >= 2000) chk("send_timeout", 64'(bus.pix_ready), 64'd1);
        tick();
    endtask

    task automatic idle_in();
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic apply_reset();
        idle_in();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
    endtask

    function automatic logic [PW-1:0] pixf(input int r, input int k);
        logic [7:0] rb;
        logic [7:0] kb;
        rb = r[7:0];
        kb = k[7:0];
        return {rb, kb, 8'hA5 ^ kb};
    endfunction

    function automatic logic [PW-1:0] pixk(input int k);
        logic [7:0] kb;
        kb = k[7:0];
        return {kb, kb, ~kb};
    endfunction

    // Directed stimulus sequence.
    initial begin
        int base;
        int fd_base;
        int bad;
        int w;
        logic [PW-1:0] sof_pix;

        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.row_ready = 1'b0;

        // Reset state while RST is held low.
        #2;
        chk("rst_row_valid",  64'(bus.row_valid), 64'd0);
        chk("rst_row_idx",    64'(bus.row_idx), 64'd0);
        chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
        chk("rst_sof_err",    64'(bus.sof_err), 64'd0);
        chk("rst_row_out_zero", 64'(bus.row_out == '0), 64'd1);
        tick();
        tick();
        RST = 1'b1;
        tick();
        chk("rst_pix_ready", 64'(bus.pix_ready), 64'd1);

        // Single row, pixel k = {k,k,~k}, consumer always ready.
        bus.row_ready = 1'b1;
        for (int k = 0; k < COL; k++) send(pixk(k), k == 0);
        idle_in();
        chk("t1_valid_before", 64'(bus.row_valid), 64'd0);
        chk("t1_full_ready",   64'(bus.pix_ready), 64'd0);
        tick();
        chk("t1_valid",   64'(bus.row_valid), 64'd1);
        chk("t1_idx",     64'(bus.row_idx), 64'd0);
        chk("t1_col0",    64'(bus.row_out[RW-1 -: PW]), 64'h0000FF);
        chk("t1_col255",  64'(bus.row_out[PW-1:0]), 64'hFFFF00);
        tick();
        chk("t1_valid_one_cycle", 64'(bus.row_valid), 64'd0);
        chk("t1_ready_again",     64'(bus.pix_ready), 64'd1);

        // Backpressure: two rows with the consumer stalled.
        apply_reset();
        bus.row_ready = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < COL; k++) send(pixf(r, k), (r == 0) && (k == 0));
        idle_in();
        chk("t2_pix_ready_low", 64'(bus.pix_ready), 64'd0);
        chk("t2_row0_valid",    64'(bus.row_valid), 64'd1);
        chk("t2_row0_idx",      64'(bus.row_idx), 64'd0);
        chk("t2_row0_col0",     64'(bus.row_out[RW-1 -: PW]), 64'(pixf(0, 0)));
        chk("t2_row0_col255",   64'(bus.row_out[PW-1:0]), 64'(pixf(0, 255)));
        repeat (5) tick();
        chk("t2_stable_idx",    64'(bus.row_idx), 64'd0);
        chk("t2_stable_col0",   64'(bus.row_out[RW-1 -: PW]), 64'(pixf(0, 0)));
        chk("t2_stable_valid",  64'(bus.row_valid), 64'd1);
        chk("t2_still_blocked", 64'(bus.pix_ready), 64'd0);
        bus.row_ready = 1'b1;
        tick();
        chk("t2_row1_valid",  64'(bus.row_valid), 64'd1);
        chk("t2_row1_idx",    64'(bus.row_idx), 64'd1);
        chk("t2_row1_col0",   64'(bus.row_out[RW-1 -: PW]), 64'(pixf(1, 0)));
        chk("t2_row1_col255", 64'(bus.row_out[PW-1:0]), 64'(pixf(1, 255)));
        tick();
        chk("t2_row1_consumed", 64'(bus.row_valid), 64'd0);

        // Mid-frame start-of-frame at column 100 of row 3.
        apply_reset();
        bus.row_ready = 1'b1;
        base = cons_n;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < COL; k++) send(pixf(r, k), (r == 0) && (k == 0));
        for (int k = 0; k < 100; k++) send(pixf(3, k), 1'b0);
        sof_pix = 24'hC0FFEE;
        send(sof_pix, 1'b1);
        chk("t3_sof_err_set", 64'(bus.sof_err), 64'd1);
        for (int k = 1; k < COL; k++) send(pixf(9, k), 1'b0);
        idle_in();
        repeat (4) tick();
        chk("t3_rows_out",     64'(cons_n - base), 64'd4);
        chk("t3_row2_idx",     64'(cons_idx[base+2]), 64'd2);
        chk("t3_restart_idx",  64'(cons_idx[base+3]), 64'd0);
        chk("t3_restart_col0", 64'(cons_col0[base+3]), 64'(sof_pix));
        chk("t3_sof_err_sticky", 64'(bus.sof_err), 64'd1);

        // Pre-frame garbage, then one complete frame with no stalls.
        apply_reset();
        chk("t4_sof_err_cleared", 64'(bus.sof_err), 64'd0);
        bus.row_ready = 1'b1;
        base    = cons_n;
        fd_base = fd_n;
        for (int g = 0; g < 10; g++) send(pixf(200, g), 1'b0);
        for (int r = 0; r < COL; r++)
            for (int k = 0; k < COL; k++) send(pixf(r, k), (r == 0) && (k == 0));
        idle_in();
        w = 0;
        while (fd_n == fd_base && w < 20) begin
            tick();
            w++;
        end
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < COL; i++) begin
            if (cons_idx[base+i] !== 8'(i)) bad++;
            if (cons_col0[base+i] !== pixf(i, 0)) bad++;
        end
        chk("t4_row_count",  64'(cons_n - base), 64'd256);
        chk("t4_order_errs", 64'(bad), 64'd0);
        chk("t4_first_col0", 64'(cons_col0[base]), 64'(pixf(0, 0)));
        chk("t4_frame_done", 64'(fd_n - fd_base), 64'd1);
        chk("t4_sof_err",    64'(bus.sof_err), 64'd0);
        chk("t4_idle_ready", 64'(bus.pix_ready), 64'd1);
        chk("t4_idle_valid", 64'(bus.row_valid), 64'd0);

        // Asynchronous reset while a row is held in row_out.
        apply_reset();
        bus.row_ready = 1'b0;
        base    = cons_n;
        fd_base = fd_n;
        for (int k = 0; k < COL; k++) send(pixf(5, k), k == 0);
        for (int k = 0; k < 50; k++) send(pixf(6, k), 1'b0);
        idle_in();
        chk("t5_valid_before", 64'(bus.row_valid), 64'd1);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("t5_async_valid", 64'(bus.row_valid), 64'd0);
        chk("t5_async_idx",   64'(bus.row_idx), 64'd0);
        chk("t5_async_ready", 64'(bus.pix_ready), 64'd1);
        #4;
        RST = 1'b1;
        bus.row_ready = 1'b1;
        tick();
        for (int k = 0; k < COL; k++) send(pixf(7, k), 1'b0);
        idle_in();
        repeat (4) tick();
        chk("t5_no_rows",       64'(cons_n - base), 64'd0);
        chk("t5_no_frame_done", 64'(fd_n - fd_base), 64'd0);
        chk("t5_valid_low",     64'(bus.row_valid), 64'd0);
        chk("t5_ready_idle",    64'(bus.pix_ready), 64'd1);
        chk("t5_sof_err",       64'(bus.sof_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
